// File: rtl/data_memory_responder_if.sv
// rtl/data_memory_responder_if.sv - request/response handshake bundle between the load/store unit and the data memory
interface data_memory_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;

  modport master (
    output req_valid, req_write, req_addr, req_funct3, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_funct3, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - RV32I byte/half/word data memory with fixed access latency; MISALIGN_FAULT_EN enables access faults
module data_memory_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  data_memory_responder_if.slave  bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [AW+1:0]  addr_q;
  logic [2:0]     f3_q;
  logic           write_q;
  logic [31:0]    wdata_q;
  logic [CW-1:0]  cnt;
  logic [31:0]    rdata_q;
  logic           err_q;
  logic [31:0]    mem [DEPTH_WORDS];

  logic           accept;
  logic           access;
  logic [AW-1:0]  idx;
  logic [31:0]    word;
  logic [7:0]     byte_v;
  logic [15:0]    half_v;
  logic [31:0]    new_word;
  logic [31:0]    acc_rdata;
  logic           acc_we;
  logic           unsupported;
  logic           fault;
  logic           unused_addr_bits;

  assign unused_addr_bits = ^bus.req_addr[31:AW+2];
  assign accept = bus.req_valid && bus.req_ready;
  assign access = (state == WAIT) && (cnt == '0);
  assign idx    = addr_q[AW+1:2];
  assign word   = mem[idx];
  assign byte_v = word[{addr_q[1:0], 3'b000} +: 8];
  assign half_v = word[{addr_q[1], 4'b0000} +: 16];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = WAIT;
      WAIT:    if (cnt == '0) state_nxt = RESP;
      RESP:    if (bus.resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state == IDLE);
    bus.resp_valid = (state == RESP);
    bus.resp_rdata = rdata_q;
    bus.resp_error = err_q;
  end

`ifdef MISALIGN_FAULT_EN
  always_comb begin
    fault = unsupported
          || (((f3_q == 3'b001) || (f3_q == 3'b101)) && addr_q[0])
          || ((f3_q == 3'b010) && (addr_q[1:0] != 2'b00));
  end
`else
  assign fault = 1'b0;
`endif

  // Lane selection and store merge for the latched request
  always_comb begin
    new_word    = word;
    acc_rdata   = '0;
    acc_we      = 1'b0;
    unsupported = 1'b0;
    if (write_q) begin
      case (f3_q)
        3'b000: begin
          new_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
          acc_we = 1'b1;
        end
        3'b001: begin
          new_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
          acc_we = 1'b1;
        end
        3'b010: begin
          new_word = wdata_q;
          acc_we   = 1'b1;
        end
        default: unsupported = 1'b1;
      endcase
    end else begin
      case (f3_q)
        3'b000:  acc_rdata = {{24{byte_v[7]}}, byte_v};
        3'b001:  acc_rdata = {{16{half_v[15]}}, half_v};
        3'b010:  acc_rdata = word;
        3'b100:  acc_rdata = {24'd0, byte_v};
        3'b101:  acc_rdata = {16'd0, half_v};
        default: unsupported = 1'b1;
      endcase
    end
    if (fault) begin
      acc_we    = 1'b0;
      acc_rdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      f3_q    <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= bus.req_addr[AW+1:0];
        f3_q    <= bus.req_funct3;
        write_q <= bus.req_write;
        wdata_q <= bus.req_wdata;
        cnt     <= CW'(LATENCY - 1);
      end
      if ((state == WAIT) && (cnt != '0)) cnt <= cnt - 1'b1;
      if (access) begin
        rdata_q <= acc_rdata;
        err_q   <= fault;
      end
    end
  end

  // Stores commit only on the WAIT->RESP edge, so a reset in WAIT drops them
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else if (access && acc_we) begin
      mem[idx] <= new_word;
    end
  end
endmodule
